row_by_col_mac_engine: RTL and testbench

//  Parametrised successor to the fixed 4-multiplier row-by-column block for the RLS datapath.

---
 rtl/row_by_col_mac_engine.sv | 129 ++++++++++++
 tb/tb_row_by_col_mac_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/row_by_col_mac_engine.sv
// Parametrised row-by-column multiply-accumulate: y = bias + sum(a[i]*b[i]) in signed fixed point,
// LANES products per beat, saturated WIDTH-bit result with a start/busy/done handshake.
module row_by_col_mac_engine #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int SIZE      = 8,
  parameter int LANES     = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  use_bias,
  input  logic [WIDTH-1:0]      bias,
  input  logic [WIDTH*SIZE-1:0] a,
  input  logic [WIDTH*SIZE-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      y,
  output logic                  ovf
);

  localparam int NBEATS = SIZE / LANES;
  localparam int KW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int PW     = 2 * WIDTH;
  localparam int ACC_W  = 2 * WIDTH - FRAC_BITS + $clog2(SIZE) + 2;

  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  if (SIZE % LANES != 0) begin : g_bad_lanes
    $error("row_by_col_mac_engine: SIZE must be a multiple of LANES");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic [WIDTH*SIZE-1:0]    a_r, b_r;
  logic [KW-1:0]            k;
  logic signed [WIDTH-1:0]  a_lane [LANES];
  logic signed [WIDTH-1:0]  b_lane [LANES];
  logic signed [PW-1:0]     prod_nxt [LANES];
  logic signed [PW-1:0]     prod [LANES];
  logic                     prod_vld;
  logic signed [ACC_W-1:0]  acc, lane_sum, acc_sum;
  logic [WIDTH-1:0]         y_sat;
  logic                     clip;
  logic                     accept, last_beat;

  assign accept    = start && (state == S_IDLE || state == S_DONE);
  assign last_beat = (k == KW'(NBEATS - 1));
  assign busy      = (state == S_RUN) || (state == S_FLUSH);
  assign done      = (state == S_DONE);

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_beat) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane l of beat k multiplies element k*LANES+l; the shift floors toward -infinity.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      a_lane[l]   = a_r[WIDTH*(int'(k)*LANES + l) +: WIDTH];
      b_lane[l]   = b_r[WIDTH*(int'(k)*LANES + l) +: WIDTH];
      prod_nxt[l] = (PW'(a_lane[l]) * PW'(b_lane[l])) >>> FRAC_BITS;
      lane_sum    = lane_sum + ACC_W'(prod[l]);
    end
    acc_sum = prod_vld ? acc + lane_sum : acc;
  end

  always_comb begin
    y_sat = acc_sum[WIDTH-1:0];
    clip  = 1'b0;
    if (acc_sum > Y_MAX) begin
      y_sat = Y_MAX[WIDTH-1:0];
      clip  = 1'b1;
    end else if (acc_sum < Y_MIN) begin
      y_sat = Y_MIN[WIDTH-1:0];
      clip  = 1'b1;
    end
  end

  // NOTE: operand capture registers carry no reset; they are always reloaded by an accepted start before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= a;
      b_r <= b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      k        <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      y        <= '0;
      ovf      <= 1'b0;
      for (int l = 0; l < LANES; l++) prod[l] <= '0;
    end else begin
      state    <= state_nxt;
      prod_vld <= (state == S_RUN);
      if (accept) begin
        k   <= '0;
        acc <= use_bias ? ACC_W'($signed(bias)) : '0;
      end else begin
        acc <= acc_sum;
        if (state == S_RUN) k <= k + KW'(1);
      end
      if (state == S_RUN) begin
        for (int l = 0; l < LANES; l++) prod[l] <= prod_nxt[l];
      end
      // The final beat's products are folded in on the same edge that publishes y.
      if (state == S_FLUSH) begin
        y   <= y_sat;
        ovf <= clip;
      end
    end
  end

endmodule

// File: tb/tb_row_by_col_mac_engine.sv
// Self-checking bench for row_by_col_mac_engine: directed corner cases plus random operands
// compared against a plain-arithmetic dot-product model.
module tb_row_by_col_mac_engine;

  localparam int W = 16;
  localparam int F = 8;
  localparam int N = 8;
  localparam int L = 4;

  logic           clk      = 1'b0;
  logic           reset_n  = 1'b0;
  logic           start    = 1'b0;
  logic           use_bias = 1'b0;
  logic [W-1:0]   bias     = '0;
  logic [W*N-1:0] a        = '0;
  logic [W*N-1:0] b        = '0;
  logic           busy, done, ovf;
  logic [W-1:0]   y;

  logic signed [W-1:0] av [N];
  logic signed [W-1:0] bv [N];
  logic signed [W-1:0] bias_v;
  logic                ub;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  row_by_col_mac_engine #(.WIDTH(W), .FRAC_BITS(F), .SIZE(N), .LANES(L)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .use_bias(use_bias), .bias(bias),
    .a(a), .b(b), .busy(busy), .done(done), .y(y), .ovf(ovf)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer dot product with per-product floor division by 2^F, then clamp.
  function automatic void model(output logic [W-1:0] ey, output logic eo);
    longint s = ub ? longint'(bias_v) : 0;
    for (int i = 0; i < N; i++) s += (longint'(av[i]) * longint'(bv[i])) >>> F;
    eo = 1'b1;
    if (s > 32767)       ey = 16'h7FFF;
    else if (s < -32768) ey = 16'h8000;
    else begin
      ey = 16'(s);
      eo = 1'b0;
    end
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      a[W*i +: W] = av[i];
      b[W*i +: W] = bv[i];
    end
    bias     = bias_v;
    use_bias = ub;
  endtask

  task automatic fill(logic [W-1:0] va, logic [W-1:0] vb);
    for (int i = 0; i < N; i++) begin
      av[i] = va;
      bv[i] = vb;
    end
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      av[i] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 2047)) - 16'd1024;
      bv[i] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 2047)) - 16'd1024;
    end
    bias_v = W'($urandom);
    ub     = 1'($urandom);
  endtask

  // mode 0: plain op; 1: extra start with new operands mid-run; 2: start held into the done cycle.
  task automatic run_op(string tag, int mode, logic [W-1:0] ey, logic eo);
    logic [W-1:0] ey2;
    logic         eo2;
    @(negedge clk);
    apply();
    start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) start = (mode == 2);
      if (mode == 1 && i == 2) begin
        for (int e = 0; e < N; e++) av[e] = W'($urandom);
        apply();
        start = 1'b1;
      end
      if (mode == 1 && i == 3) start = 1'b0;
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_nodone"}, done, 1'b0);
    end
    @(negedge clk);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_y"}, y, ey);
    check({tag, "_ovf"}, ovf, eo);
    if (mode == 2) begin
      randomize_ops();
      model(ey2, eo2);
      apply();
      for (int i = 1; i <= 3; i++) begin
        @(negedge clk);
        start = 1'b0;
        check({tag, "_b2b_busy"}, busy, 1'b1);
        check({tag, "_b2b_nodone"}, done, 1'b0);
      end
      @(negedge clk);
      check({tag, "_b2b_done"}, done, 1'b1);
      check({tag, "_b2b_y"}, y, ey2);
      check({tag, "_b2b_ovf"}, ovf, eo2);
      ey = ey2;
      eo = eo2;
    end
    @(negedge clk);
    check({tag, "_pulse_end"}, done, 1'b0);
    check({tag, "_y_hold"}, y, ey);
  endtask

  initial begin
    logic [W-1:0] ey;
    logic         eo;

    bias_v = '0;
    ub     = 1'b0;
    fill('0, '0);
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_y", y, 16'h0000);
    check("reset_ovf", ovf, 1'b0);
    reset_n = 1'b1;

    fill(16'h0100, 16'h0200);
    run_op("t1_unity", 0, 16'h1000, 1'b0);

    fill(16'h7FFF, 16'h7FFF);
    run_op("t2_pos_sat", 0, 16'h7FFF, 1'b1);
    fill(16'hFF00, 16'h7FFF);
    run_op("t2_neg_sat", 0, 16'h8000, 1'b1);

    fill('0, '0);
    av[0] = 16'h0100; bv[0] = 16'h0100; bias_v = 16'h0080; ub = 1'b1;
    run_op("t3_bias", 0, 16'h0180, 1'b0);
    ub = 1'b0;
    run_op("t3_nobias", 0, 16'h0100, 1'b0);

    av[0] = 16'hFFFF; bv[0] = 16'h0001;
    run_op("t4_floor_neg", 0, 16'hFFFF, 1'b0);
    av[0] = 16'h0001;
    run_op("t4_floor_pos", 0, 16'h0000, 1'b0);

    fill(16'h0100, 16'h0200);
    run_op("t5_ignore", 1, 16'h1000, 1'b0);
    fill(16'h0100, 16'h0200);
    ub = 1'b0;
    run_op("t5_b2b", 2, 16'h1000, 1'b0);

    // Reset two edges into an op: no done pulse, outputs cleared, then a clean op.
    fill(16'h0100, 16'h0200);
    ub = 1'b0;
    @(negedge clk);
    apply();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_done", done, 1'b0);
    check("t6_rst_y", y, 16'h0000);
    check("t6_rst_ovf", ovf, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_no_done", done, 1'b0);
    end
    fill(16'h0200, 16'h0300);
    run_op("t6_fresh", 0, 16'h3000, 1'b0);

    for (int t = 0; t < 20; t++) begin
      randomize_ops();
      model(ey, eo);
      run_op($sformatf("rand%0d", t), 0, ey, eo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
